cu_fsm: RTL and testbench
=========================

Name: cu_fsm

Overview:
- Parametrised multi-cycle successor to the single-cycle control unit.
- Accepts one instruction word over a valid/ready handshake and steps it through DECODE, EXEC and WB.
- Drives register-file read/write addresses, ALU operation select and a one-cycle write enable.
- Sits between the instruction source and the register file / ALU datapath of the experiment CPU.

Parameters:
- OP_W, 7, opcode field width.
- REG_AW, 3, register address width (register file depth 2**REG_AW).
- ALU_OP_W, 3, ALU operation select width.
- INSTR_W, OP_W+3*REG_AW (16), instruction width; derived, must not be overridden.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- instr_valid  in  1  instruction word present.
- instr_ready  out  1  block can accept an instruction.
- instr  in  INSTR_W  instruction word {opcode, rs2, rs1, rd}, MSB to LSB.
- rf_ra  out  REG_AW  register file read address A (rs1).
- rf_rb  out  REG_AW  register file read address B (rs2).
- rf_wa  out  REG_AW  register file write address (rd).
- wr_en  out  1  register file write enable.
- alu_op  out  ALU_OP_W  ALU operation select.
- busy  out  1  instruction in flight.
- done  out  1  one-cycle pulse when an instruction retires (including NOP and illegal).
- illegal  out  1  one-cycle pulse: undefined opcode decoded.

Behaviour:
- Single clock domain; reset is asynchronous and active-low on rst_n.
- Reset values:
  - State is IDLE; instr_ready=1.
  - All other outputs 0: rf_ra, rf_rb, rf_wa, alu_op, wr_en, busy, done, illegal.
- States: IDLE, DECODE, EXEC, WB.
- IDLE:
  - instr_ready=1, busy=0.
  - When instr_valid&&instr_ready, latch instr into the internal IR and go to DECODE.
  - instr is ignored when instr_valid=0.
- DECODE:
  - busy=1, instr_ready=0.
  - rf_ra/rf_rb/rf_wa are driven from the IR and held stable through WB.
  - Opcode map: 0 NOP, 1 ADD (alu_op=0), 2 SUB (1), 3 AND (2), 4 OR (3), 5 XOR (4). All other opcodes are illegal.
  - NOP: done=1 this cycle, then IDLE.
  - Illegal: illegal=1 and done=1 this cycle, then IDLE; no write.
  - Legal ALU op: go to EXEC.
- EXEC:
  - alu_op is valid and held through WB.
  - wr_en=0.
  - Always goes to WB.
- WB:
  - wr_en=1 for exactly this cycle; done=1.
  - Then IDLE, where alu_op returns to 0.
- Latency: handshake at edge T gives DECODE in cycle T+1, EXEC in T+2, WB (wr_en=1) in T+3; instr_ready=1 again in T+4.
- Throughput: one ALU instruction per 4 cycles; one NOP or illegal instruction per 2 cycles.
- rd=0 is a normal writable register; no hard-wired zero.
- rs1, rs2 and rd may be equal; no hazard logic is required, since there is a single instruction in flight.
- Changes on instr while not in IDLE have no effect.
- Reset asserted mid-instruction: the next state is IDLE immediately, wr_en drops at once, and no partial write occurs.
- Unused opcode MSBs are decoded in full; e.g. opcode 7'h41 is illegal, not ADD.

Optional Feature:
- Macro: CU_PERF_CNT_EN.
- Defined:
  - Adds output retired_cnt (32 bits): increments on every done pulse and wraps 0xFFFFFFFF→0.
  - Adds output illegal_cnt (16 bits): increments on every illegal pulse and saturates at 0xFFFF.
  - Both counters reset to 0 on rst_n.
- Undefined: these ports and counters are absent; all other behaviour is identical.

Test Plan:
- Reset: hold rst_n=0, then release.
  - Required: instr_ready=1, every other output 0.
- ADD instr=16'b000_0001_001_000_000 with valid for one cycle.
  - Required: rf_ra=0, rf_rb=1, rf_wa=0.
  - Required: alu_op=0 from EXEC; wr_en=1 and done=1 exactly 3 cycles after the handshake.
  - Required: instr_ready=1 one cycle later.
- Back-to-back: hold valid high with 000_0001_100_010_100, then 000_0001_010_001_001.
  - Required: the second instruction is accepted exactly 4 cycles after the first.
  - Required: first write has rf_wa=4, second has rf_wa=1; no overlap between them.
- NOP 16'h0000, then illegal opcode 7'h41.
  - Required: each gives done in the DECODE cycle with wr_en never 1.
  - Required: illegal=1 only for the second.
  - With CU_PERF_CNT_EN: retired_cnt=2, illegal_cnt=1.
- Reset mid-flight: assert rst_n=0 during the EXEC of a SUB.
  - Required: wr_en never asserts; state returns to IDLE with all outputs at reset values.
- Valid while busy: hold instr_valid=1 with changing instr during DECODE/EXEC.
  - Required: instr_ready=0 throughout; outputs reflect only the originally latched instruction.

Source files
------------

// File: rtl/cu_fsm.sv
// cu_fsm: multi-cycle control unit. Accepts one instruction word over a
// valid/ready handshake and steps it through DECODE -> EXEC -> WB, driving
// register-file addresses, ALU operation select and a one-cycle write enable.
//
// Ports:
//   clk, rst_n        clock (rising edge), asynchronous active-low reset
//   instr_valid/ready handshake for instr = {opcode, rs2, rs1, rd}
//   rf_ra, rf_rb      register read addresses (rs1, rs2)
//   rf_wa, wr_en      register write address (rd) and one-cycle write enable
//   alu_op            ALU operation select (valid in EXEC and WB)
//   busy              instruction in flight
//   done              one-cycle retire pulse (ALU op, NOP or illegal)
//   illegal           one-cycle pulse when an undefined opcode is decoded
//
// Optional build macro CU_PERF_CNT_EN adds:
//   retired_cnt [31:0] wrapping count of done pulses
//   illegal_cnt [15:0] saturating count of illegal pulses
module cu_fsm #(
  parameter  int OP_W     = 7,
  parameter  int REG_AW   = 3,
  parameter  int ALU_OP_W = 3,
  localparam int INSTR_W  = OP_W + 3*REG_AW
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                instr_valid,
  output logic                instr_ready,
  input  logic [INSTR_W-1:0]  instr,
  output logic [REG_AW-1:0]   rf_ra,
  output logic [REG_AW-1:0]   rf_rb,
  output logic [REG_AW-1:0]   rf_wa,
  output logic                wr_en,
  output logic [ALU_OP_W-1:0] alu_op,
  output logic                busy,
  output logic                done,
  output logic                illegal
`ifdef CU_PERF_CNT_EN
  ,output logic [31:0]        retired_cnt
  ,output logic [15:0]        illegal_cnt
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_DECODE, S_EXEC, S_WB} state_e;

  typedef struct packed {
    logic [OP_W-1:0]   op;
    logic [REG_AW-1:0] rs2;
    logic [REG_AW-1:0] rs1;
    logic [REG_AW-1:0] rd;
  } ir_t;

  state_e state, state_nxt;
  ir_t    ir;

  logic                is_nop, is_alu;
  logic [ALU_OP_W-1:0] dec_alu;

  // Full-width opcode compare: unused MSBs must be zero for a legal op.
  always_comb begin
    is_nop  = 1'b0;
    is_alu  = 1'b1;
    dec_alu = '0;
    case (ir.op)
      OP_W'(0): begin is_nop = 1'b1; is_alu = 1'b0; end
      OP_W'(1): dec_alu = ALU_OP_W'(0);
      OP_W'(2): dec_alu = ALU_OP_W'(1);
      OP_W'(3): dec_alu = ALU_OP_W'(2);
      OP_W'(4): dec_alu = ALU_OP_W'(3);
      OP_W'(5): dec_alu = ALU_OP_W'(4);
      default:  is_alu = 1'b0;
    endcase
  end

  // State and instruction register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      ir    <= '0;
    end else begin
      state <= state_nxt;
      if (state == S_IDLE && instr_valid) ir <= ir_t'(instr);
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (instr_valid) state_nxt = S_DECODE;
      S_DECODE: state_nxt = is_alu ? S_EXEC : S_IDLE;
      S_EXEC:   state_nxt = S_WB;
      S_WB:     state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  // Outputs are decoded from state so that reset clears them (and wr_en)
  // immediately, without waiting for a clock edge.
  always_comb begin
    instr_ready = 1'b0;
    busy        = 1'b0;
    rf_ra       = '0;
    rf_rb       = '0;
    rf_wa       = '0;
    alu_op      = '0;
    wr_en       = 1'b0;
    done        = 1'b0;
    illegal     = 1'b0;
    case (state)
      S_IDLE: instr_ready = 1'b1;
      S_DECODE: begin
        busy    = 1'b1;
        rf_ra   = ir.rs1;
        rf_rb   = ir.rs2;
        rf_wa   = ir.rd;
        done    = ~is_alu;
        illegal = ~is_alu & ~is_nop;
      end
      S_EXEC: begin
        busy   = 1'b1;
        rf_ra  = ir.rs1;
        rf_rb  = ir.rs2;
        rf_wa  = ir.rd;
        alu_op = dec_alu;
      end
      S_WB: begin
        busy   = 1'b1;
        rf_ra  = ir.rs1;
        rf_rb  = ir.rs2;
        rf_wa  = ir.rd;
        alu_op = dec_alu;
        wr_en  = 1'b1;
        done   = 1'b1;
      end
      default: ;
    endcase
  end

`ifdef CU_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      retired_cnt <= '0;
      illegal_cnt <= '0;
    end else begin
      if (done) retired_cnt <= retired_cnt + 32'd1;
      if (illegal && illegal_cnt != 16'hFFFF) illegal_cnt <= illegal_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_cu_fsm.sv
// Self-checking bench for cu_fsm. A reference model turns each accepted
// instruction into its list of expected per-cycle output records (taken
// from the latency table: 2 cycles for NOP/illegal incl. return to idle,
// 4 for ALU ops) and every cycle compares the DUT against the next record.
module tb_cu_fsm;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        instr_valid;
  logic        instr_ready;
  logic [15:0] instr;
  logic [2:0]  rf_ra, rf_rb, rf_wa, alu_op;
  logic        wr_en, busy, done, illegal;
`ifdef CU_PERF_CNT_EN
  logic [31:0] retired_cnt;
  logic [15:0] illegal_cnt;
`endif

  cu_fsm dut (
    .clk(clk), .rst_n(rst_n), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr(instr), .rf_ra(rf_ra), .rf_rb(rf_rb), .rf_wa(rf_wa), .wr_en(wr_en),
    .alu_op(alu_op), .busy(busy), .done(done), .illegal(illegal)
`ifdef CU_PERF_CNT_EN
    , .retired_cnt(retired_cnt), .illegal_cnt(illegal_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       ready, busy;
    logic [2:0] ra, rb, wa, alu;
    logic       wr, done, ill;
  } rec_t;

  localparam rec_t IDLE_REC = '{ready: 1'b1, busy: 1'b0, ra: 3'd0, rb: 3'd0,
                                wa: 3'd0, alu: 3'd0, wr: 1'b0, done: 1'b0, ill: 1'b0};

  rec_t  q[$];
  logic  cur_idle;
  int    total = 0, bad = 0;
  int    n_wr = 0;
  longint m_ret = 0;
  int    m_ill = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected per-cycle trace of one instruction, straight from the opcode map.
  task automatic push_instr(input logic [15:0] w);
    int   op;
    rec_t r;
    op = int'(w[15:9]);
    r  = IDLE_REC;
    r.ready = 1'b0; r.busy = 1'b1;
    r.rb = w[8:6]; r.ra = w[5:3]; r.wa = w[2:0];
    if (op >= 1 && op <= 5) begin
      q.push_back(r);                        // DECODE
      r.alu = 3'(op - 1);
      q.push_back(r);                        // EXEC
      r.wr = 1'b1; r.done = 1'b1;
      q.push_back(r);                        // WB
    end else begin
      r.done = 1'b1; r.ill = (op != 0);
      q.push_back(r);                        // DECODE retires directly
    end
  endtask

  task automatic cmp_rec(input string tag, input rec_t e);
    chk({tag, ".ready"},   32'(instr_ready), 32'(e.ready));
    chk({tag, ".busy"},    32'(busy),        32'(e.busy));
    chk({tag, ".ra"},      32'(rf_ra),       32'(e.ra));
    chk({tag, ".rb"},      32'(rf_rb),       32'(e.rb));
    chk({tag, ".wa"},      32'(rf_wa),       32'(e.wa));
    chk({tag, ".alu"},     32'(alu_op),      32'(e.alu));
    chk({tag, ".wr_en"},   32'(wr_en),       32'(e.wr));
    chk({tag, ".done"},    32'(done),        32'(e.done));
    chk({tag, ".illegal"}, 32'(illegal),     32'(e.ill));
  endtask

  // One clock: drive on negedge, model the handshake at posedge, check #1 later.
  task automatic step(input string tag, input logic v, input logic [15:0] w);
    rec_t e;
    logic hs;
    @(negedge clk);
    instr_valid = v;
    instr       = w;
    @(posedge clk);
    hs = cur_idle && v;
    #1;
    if (hs) push_instr(w);
    e = (q.size() != 0) ? q.pop_front() : IDLE_REC;
    cmp_rec(tag, e);
`ifdef CU_PERF_CNT_EN
    chk({tag, ".retired_cnt"}, retired_cnt, 32'(m_ret));
    chk({tag, ".illegal_cnt"}, 32'(illegal_cnt), 32'(m_ill));
    if (e.done) m_ret = (m_ret + 1) & 64'hFFFF_FFFF;
    if (e.ill && m_ill != 16'hFFFF) m_ill++;
`endif
    if (e.wr) n_wr++;
    cur_idle = e.ready;
  endtask

  task automatic model_reset();
    q.delete();
    cur_idle = 1'b1;
    m_ret = 0;
    m_ill = 0;
  endtask

  initial begin
    logic [15:0] w;
    int          wr0;
    rst_n = 1'b0; instr_valid = 1'b0; instr = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #1 cmp_rec("reset_held", IDLE_REC);
    @(negedge clk) rst_n = 1'b1;
    step("after_reset", 1'b0, 16'hFFFF);

    // Single ADD: ra=0 rb=1 wa=0, write 3 cycles after handshake.
    step("add.hs",   1'b1, 16'b0000001_001_000_000);
    step("add.exec", 1'b0, 16'h0);
    step("add.wb",   1'b0, 16'h0);
    step("add.idle", 1'b0, 16'h0);

    // Back-to-back with valid held high: accepts 4 cycles apart.
    wr0 = n_wr;
    for (int i = 0; i < 4; i++) step("b2b.first",  1'b1, 16'b0000001_100_010_100);
    for (int i = 0; i < 4; i++) step("b2b.second", 1'b1, 16'b0000001_010_001_001);
    step("b2b.tail", 1'b0, 16'h0);
    chk("b2b.writes", 32'(n_wr - wr0), 32'd2);

    // NOP then illegal opcode 7'h41 (not ADD).
    wr0 = n_wr;
    step("nop.hs",  1'b1, 16'h0000);
    step("nop.idle", 1'b0, 16'h0);
    step("ill.hs",  1'b1, {7'h41, 3'd5, 3'd6, 3'd7});
    step("ill.idle", 1'b0, 16'h0);
    chk("nop_ill.writes", 32'(n_wr - wr0), 32'd0);

    // Valid while busy with a changing word: only the first is seen.
    step("busy.hs", 1'b1, {7'd4, 3'd3, 3'd2, 3'd1});
    for (int i = 0; i < 3; i++) step("busy.hold", 1'b1, 16'($urandom));

    // Reset during EXEC of a SUB: outputs drop at once, no write.
    while (!cur_idle) step("drain", 1'b0, 16'h0);
    wr0 = n_wr;
    step("sub.hs",   1'b1, {7'd2, 3'd7, 3'd6, 3'd5});
    step("sub.exec", 1'b0, 16'h0);
    rst_n = 1'b0;
    #1 cmp_rec("midrst.now", IDLE_REC);
    model_reset();
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      cmp_rec("midrst.held", IDLE_REC);
    end
    @(negedge clk) rst_n = 1'b1;
    step("midrst.after", 1'b0, 16'h0);
    chk("midrst.writes", 32'(n_wr - wr0), 32'd0);

    // Randomized traffic: mostly legal/NOP opcodes, some full-width garbage.
    for (int i = 0; i < 600; i++) begin
      w = 16'($urandom);
      if ($urandom_range(0, 3) != 0) w[15:9] = 7'($urandom_range(0, 6));
      step("rand", ($urandom_range(0, 9) < 7), w);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Overall time bound so the bench always terminates.
  initial begin
    #200000;
    $display("FAIL timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

endmodule
